// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared state type, default sizes and one-hot helper for the DM arbiter
// Items: state_t (IDLE/ACCESS/RESP), DM_NUM_CORES/DM_ADDR_W/DM_DATA_W defaults, oh2idx()
package dm_arb_pkg;
   localparam int DM_NUM_CORES = 4;
   localparam int DM_ADDR_W = 16;
   localparam int DM_DATA_W = 16;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   function automatic int oh2idx(input logic [7:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < 8; i++) if (oh[i]) idx = i;
      return idx;
   endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational winner selection among requesting cores
// Ports: req (per-core requests), last (previous winner index),
//        win (one-hot winner, zero if no request), win_idx (winner index)
// Macro: DM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins, last ignored)
module rr_picker import dm_arb_pkg::*; #(
   parameter int N = DM_NUM_CORES,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  win,
   output logic [IW-1:0] win_idx
);
`ifdef DM_ARB_FIXED_PRIO_EN
   logic unused_last;
   assign unused_last = ^last;
   always_comb begin
      win = '0;
      for (int i = N - 1; i >= 0; i--) if (req[i]) win = N'(1) << i;
   end
`else
   int j;
   // Scan from farthest to nearest after last so the nearest requester overwrites.
   always_comb begin
      win = '0;
      j = 0;
      for (int k = N; k >= 1; k--) begin
         j = (int'(last) + k) % N;
         if (req[j[IW-1:0]]) win = N'(1) << j;
      end
   end
`endif
   assign win_idx = IW'(oh2idx(8'(win)));
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin sharing of the single-port data memory between cores
// Ports: clk, rst (sync, active-high); req/we/addr/wdata (per-core, packed);
//        grant (one-hot owner), ack (one-cycle completion), rdata (read data on ack);
//        mem_addr/mem_wdata/mem_we to the RAM, mem_rdata from the RAM (1-cycle latency)
// Macro: DM_ARB_FIXED_PRIO_EN switches to fixed priority and drops the last pointer
module dm_arbiter import dm_arb_pkg::*; #(
   parameter int NUM_CORES = DM_NUM_CORES,
   parameter int ADDR_W = DM_ADDR_W,
   parameter int DATA_W = DM_DATA_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CORES-1:0]        req,
   input  logic [NUM_CORES-1:0]        we,
   input  logic [NUM_CORES*ADDR_W-1:0] addr,
   input  logic [NUM_CORES*DATA_W-1:0] wdata,
   output logic [NUM_CORES-1:0]        grant,
   output logic [NUM_CORES-1:0]        ack,
   output logic [DATA_W-1:0]           rdata,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   output logic                        mem_we,
   input  logic [DATA_W-1:0]           mem_rdata
);
   localparam int IW = $clog2(NUM_CORES);
   state_t state, nxt;
   logic [NUM_CORES-1:0] pick;
   logic [IW-1:0] pick_idx, last;
   logic lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic take;
   assign take = state == IDLE && |req;
   rr_picker #(.N(NUM_CORES)) u_pick (.req(req), .last(last), .win(pick), .win_idx(pick_idx));
`ifdef DM_ARB_FIXED_PRIO_EN
   assign last = '0;
`else
   always_ff @(posedge clk)
      if (rst) last <= IW'(NUM_CORES - 1);
      else if (take) last <= pick_idx;
`endif
   always_ff @(posedge clk) state <= rst ? IDLE : nxt;
   always_comb nxt = state == IDLE ? (|req ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
   always_ff @(posedge clk)
      if (rst) begin
         grant <= '0;
         lat_we <= 1'b0;
         lat_addr <= '0;
         lat_wdata <= '0;
      end else if (take) begin
         grant <= pick;
         lat_we <= we[pick_idx];
         lat_addr <= addr[int'(pick_idx)*ADDR_W +: ADDR_W];
         lat_wdata <= wdata[int'(pick_idx)*DATA_W +: DATA_W];
      end else if (state == RESP) grant <= '0;
   // rst gates mem_we directly so a write caught by reset never reaches the RAM.
   always_comb begin
      ack = state == RESP ? grant : '0;
      rdata = state == RESP && !lat_we ? mem_rdata : '0;
      mem_addr = state == ACCESS ? lat_addr : '0;
      mem_wdata = state == ACCESS ? lat_wdata : '0;
      mem_we = state == ACCESS && lat_we && !rst;
   end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: table, directed and randomized checks of dm_arbiter against a RAM and reference model
module tb_dm_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] req, we, grant, ack;
   logic [63:0] addr, wdata;
   logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic mem_we;
   logic [3:0] d_req = '0, d_we = '0;
   logic [15:0] d_addr[4] = '{default: 16'h0};
   logic [15:0] d_wd[4] = '{default: 16'h0};
   logic [15:0] ram[256] = '{default: 16'h0};
   int passed = 0, total = 0;

   dm_arbiter dut (.clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .grant(grant), .ack(ack), .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[7:0]];
   end

   always_comb begin
      req = d_req;
      we = d_we;
      addr = '0;
      wdata = '0;
      for (int i = 0; i < 4; i++) begin
         addr[i*16 +: 16] = d_addr[i];
         wdata[i*16 +: 16] = d_wd[i];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) $display("FAIL %s: got %h expected %h", n, a, e);
      else passed++;
   endtask

   task automatic set_req(input int c, input logic w, input logic [15:0] a, input logic [15:0] d);
      d_req[c] = 1'b1;
      d_we[c] = w;
      d_addr[c] = a;
      d_wd[c] = d;
   endtask

   task automatic chk_quiet(input string n);
      chk({n, "_grant"}, grant, 0);
      chk({n, "_ack"}, ack, 0);
      chk({n, "_rdata"}, rdata, 0);
      chk({n, "_mem_we"}, mem_we, 0);
      chk({n, "_mem_addr"}, mem_addr, 0);
      chk({n, "_mem_wdata"}, mem_wdata, 0);
   endtask

   function automatic int model_pick(input int lst, input logic [3:0] r);
`ifdef DM_ARB_FIXED_PRIO_EN
      for (int c = 0; c < 4; c++) if (r[c]) return c;
`else
      for (int k = 1; k <= 4; k++) if (r[(lst + k) % 4]) return (lst + k) % 4;
`endif
      return -1;
   endfunction

   typedef struct {
      logic [3:0] req;
      logic [3:0] exp_rr;
      logic [3:0] exp_fx;
   } vec_t;
   vec_t tbl[12];

   int cur, phase, mlast;
   logic [15:0] mm[16];
   logic mwe;
   logic [15:0] maddr, mwd;
   logic [3:0] s_req, s_we;
   logic [15:0] s_addr[4], s_wd[4];

   initial begin
      tbl = '{
         '{4'b1111, 4'b0001, 4'b0001}, '{4'b1111, 4'b0010, 4'b0001},
         '{4'b1111, 4'b0100, 4'b0001}, '{4'b1111, 4'b1000, 4'b0001},
         '{4'b1111, 4'b0001, 4'b0001}, '{4'b1010, 4'b0010, 4'b0010},
         '{4'b1010, 4'b1000, 4'b0010}, '{4'b1010, 4'b0010, 4'b0010},
         '{4'b0001, 4'b0001, 4'b0001}, '{4'b0001, 4'b0001, 4'b0001},
         '{4'b1100, 4'b0100, 4'b0100}, '{4'b0101, 4'b0001, 4'b0001}};
      for (int i = 0; i < 4; i++) d_addr[i] = 16'(i);
      step();
      step();
      chk_quiet("reset");
      rst = 1'b0;
      step();
      chk_quiet("idle");
      // arbitration order from reset, each transaction three cycles apart
      for (int v = 0; v < 12; v++) begin
         d_req = tbl[v].req;
         step();
`ifdef DM_ARB_FIXED_PRIO_EN
         chk($sformatf("tbl%0d_grant", v), grant, tbl[v].exp_fx);
`else
         chk($sformatf("tbl%0d_grant", v), grant, tbl[v].exp_rr);
`endif
         chk($sformatf("tbl%0d_ack_early", v), ack, 0);
         step();
`ifdef DM_ARB_FIXED_PRIO_EN
         chk($sformatf("tbl%0d_ack", v), ack, tbl[v].exp_fx);
`else
         chk($sformatf("tbl%0d_ack", v), ack, tbl[v].exp_rr);
`endif
         d_req = '0;
         step();
         chk($sformatf("tbl%0d_gap", v), grant | ack, 0);
      end
      // single write then read back
      set_req(2, 1'b1, 16'h0010, 16'hBEEF);
      step();
      chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_addr", mem_addr, 16'h0010);
      chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
      chk("wr_ack_early", ack, 0);
      step();
      chk("wr_mem_we_off", mem_we, 0);
      chk("wr_ack", ack, 4'b0100);
      chk("wr_rdata", rdata, 0);
      d_req = '0;
      step();
      chk("wr_after", ack, 0);
      set_req(0, 1'b0, 16'h0010, 16'h0);
      step();
      chk("rd_mem_addr", mem_addr, 16'h0010);
      chk("rd_mem_we", mem_we, 0);
      step();
      chk("rd_ack", ack, 4'b0001);
      chk("rd_rdata", rdata, 16'hBEEF);
      d_req = '0;
      step();
      // early drop of request during ACCESS
      set_req(1, 1'b0, 16'h0010, 16'h0);
      step();
      d_req[1] = 1'b0;
      chk("drop_grant", grant, 4'b0010);
      step();
      chk("drop_ack", ack, 4'b0010);
      chk("drop_rdata", rdata, 16'hBEEF);
      step();
      // owner changes address during ACCESS
      set_req(3, 1'b0, 16'h0004, 16'h0);
      step();
      d_addr[3] = 16'h0008;
      #1;
      chk("chg_mem_addr", mem_addr, 16'h0004);
      step();
      chk("chg_ack", ack, 4'b1000);
      d_req = '0;
      step();
      // reset while a write is in ACCESS
      set_req(1, 1'b1, 16'h0020, 16'h1234);
      step();
      chk("rstw_mem_we_pre", mem_we, 1);
      rst = 1'b1;
      #1;
      chk("rstw_mem_we_abort", mem_we, 0);
      step();
      chk_quiet("rstw");
      chk("rstw_ram", ram[8'h20], 0);
      rst = 1'b0;
      d_req = 4'b1111;
      step();
      chk("rstw_first", grant, 4'b0001);
      step();
      chk("rstw_ack", ack, 4'b0001);
      d_req = '0;
      step();
`ifdef DM_ARB_FIXED_PRIO_EN
      d_req = 4'b1001;
      for (int n = 0; n < 3; n++) begin
         step();
         chk("fx_grant0", grant, 4'b0001);
         step();
         step();
      end
      d_req = 4'b1000;
      step();
      chk("fx_grant3", grant, 4'b1000);
      step();
      d_req = '0;
      step();
`endif
      // randomized traffic against the reference model
      rst = 1'b1;
      d_req = '0;
      step();
      rst = 1'b0;
      mlast = 3;
      cur = -1;
      phase = 0;
      for (int i = 0; i < 16; i++) mm[i] = '0;
      for (int cyc = 0; cyc < 900; cyc++) begin
         s_req = d_req;
         s_we = d_we;
         s_addr = d_addr;
         s_wd = d_wd;
         step();
         if (phase == 0) begin
            if (|s_req) begin
               cur = model_pick(mlast, s_req);
               mlast = cur;
               mwe = s_we[cur];
               maddr = s_addr[cur];
               mwd = s_wd[cur];
               chk("rnd_grant", grant, 32'(1) << cur);
               chk("rnd_ack_early", ack, 0);
               chk("rnd_mem_we", mem_we, mwe);
               chk("rnd_mem_addr", mem_addr, maddr);
               chk("rnd_mem_wdata", mem_wdata, mwd);
               if ($urandom_range(3) == 0) begin
                  d_addr[cur] = 16'($urandom_range(15));
                  d_wd[cur] = 16'($urandom);
                  d_we[cur] = 1'($urandom_range(1));
                  if ($urandom_range(1) == 0) d_req[cur] = 1'b0;
               end
               phase = 1;
            end else begin
               chk("rnd_idle_grant", grant, 0);
               chk("rnd_idle_we", mem_we, 0);
            end
         end else if (phase == 1) begin
            chk("rnd_ack", ack, 32'(1) << cur);
            chk("rnd_rdata", rdata, mwe ? 16'h0 : mm[maddr[3:0]]);
            chk("rnd_resp_we", mem_we, 0);
            if (mwe) mm[maddr[3:0]] = mwd;
            if ($urandom_range(1) == 0) set_req(cur, 1'($urandom_range(1)), 16'($urandom_range(15)), 16'($urandom));
            else d_req[cur] = 1'b0;
            phase = 2;
         end else begin
            chk("rnd_gap", grant | ack, 0);
            phase = 0;
         end
         for (int i = 0; i < 4; i++)
            if (!d_req[i] && !(phase == 1 && i == cur) && $urandom_range(2) == 0)
               set_req(i, 1'($urandom_range(1)), 16'($urandom_range(15)), 16'($urandom));
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
